// File: rtl/fifo.sv
// Synchronous single-clock FIFO with a registered read port.
// Define FIFO_STATUS_EN to add sticky overflow/underflow flags.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] writeData,
    input  logic             writeEn,
    input  logic             readEn,
    output logic [WIDTH-1:0] readData,
    output logic             full,
    output logic             empty
`ifdef FIFO_STATUS_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign wr_ok = writeEn && !full;
    assign rd_ok = readEn && !empty;

    // Storage is never cleared; stale words are unreachable after reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            mem[wr_ptr] <= writeData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            readData <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                readData <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_STATUS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (writeEn && full);
            underflow <= underflow | (readEn && empty);
        end
    end
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed plus randomized bench for fifo against a queue-based model.
// Checks run #1 after each rising edge.
module tb_fifo;

    localparam int W = 8;
    localparam int D = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] writeData;
    logic         writeEn;
    logic         readEn;
    logic [W-1:0] readData;
    logic         full;
    logic         empty;
`ifdef FIFO_STATUS_EN
    logic         overflow;
    logic         underflow;
`endif

    fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .writeData(writeData),
        .writeEn(writeEn),
        .readEn(readEn),
        .readData(readData),
        .full(full),
        .empty(empty)
`ifdef FIFO_STATUS_EN
        ,
        .overflow(overflow),
        .underflow(underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] m_rd = '0;
    logic         m_ov = 1'b0;
    logic         m_un = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic we, input logic re,
                        input logic [W-1:0] wd);
        logic was_full;
        logic was_empty;
        rst_n     = r;
        writeEn   = we;
        readEn    = re;
        writeData = wd;
        @(posedge clk);
        was_full  = (q.size() == D);
        was_empty = (q.size() == 0);
        if (!r) begin
            q.delete();
            m_rd = '0;
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            if (re && !was_empty) m_rd = q.pop_front();
            if (we && !was_full) q.push_back(wd);
            if (we && was_full) m_ov = 1'b1;
            if (re && was_empty) m_un = 1'b1;
        end
        #1;
        chk("readData", 32'(readData), 32'(m_rd));
        chk("full", 32'(full), 32'(q.size() == D));
        chk("empty", 32'(empty), 32'(q.size() == 0));
`ifdef FIFO_STATUS_EN
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
`endif
    endtask

    initial begin
        logic [W-1:0] v;
        rst_n     = 1'b0;
        writeEn   = 1'b0;
        readEn    = 1'b0;
        writeData = '0;

        // reset, then single write/read
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("rd_0x01", 32'(readData), 32'h01);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // fill, overfill, drain
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, W'(i));
        chk("full_after_8", 32'(full), 32'h1);
        step(1'b1, 1'b1, 1'b0, 8'h09);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00);
            chk("drain_order", 32'(readData), 32'(i));
        end
        chk("empty_after_drain", 32'(empty), 32'h1);

        // read while empty holds data
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("hold_on_underflow", 32'(readData), 32'h08);
        // write+read on empty: only the write is taken
        step(1'b1, 1'b1, 1'b1, 8'h55);
        chk("rd_ignored_empty", 32'(readData), 32'h08);

        // steady state at count 4 across wrap
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, W'(8'h10 + i));
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b1, W'(8'h14 + i));
            chk("rw_order", 32'(readData), 32'(8'h10 + i));
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("rw_tail", 32'(readData), 32'h1f);

        // full plus simultaneous read: write still refused
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, W'(8'h30 + i));
        step(1'b1, 1'b1, 1'b1, 8'h99);
        chk("full_rw_rd", 32'(readData), 32'h30);

        // reset mid-operation with a write pending
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, W'(8'h40 + i));
        step(1'b0, 1'b1, 1'b1, 8'h77);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_rd", 32'(readData), 32'h0);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("rst_discard", 32'(readData), 32'h0);

        // randomized traffic with phase-biased read/write mix
        for (int i = 0; i < 600; i++) begin
            int wp;
            int rp;
            wp = ((i / 50) % 2 == 0) ? 75 : 25;
            rp = 100 - wp;
            v  = W'($urandom);
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 99) < wp),
                 ($urandom_range(0, 99) < rp), v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, SHALL be >= 1.
REQ-002 Parameter DEPTH, default 8: number of storage entries, SHALL be a power of two >= 2.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 writeData  input  WIDTH  word to enqueue.
REQ-006 writeEn  input  1  write request, sampled at rising edge.
REQ-007 readEn  input  1  read request, sampled at rising edge.
REQ-008 readData  output  WIDTH  registered dequeued word.
REQ-009 full  output  1  high when the FIFO holds DEPTH words.
REQ-010 empty  output  1  high when the FIFO holds 0 words.
REQ-011 overflow, underflow  output  1 each  sticky error flags, present only with FIFO_STATUS_EN (REQ-028).

Function
REQ-012 Storage SHALL be a DEPTH x WIDTH array with write pointer, read pointer and occupancy count of clog2(DEPTH)+1 bits.
REQ-013 Accepted write: writeEn=1 and full=0 at edge -> writeData stored at write pointer, write pointer +1 mod DEPTH, count +1.
REQ-014 Accepted read: readEn=1 and empty=0 at edge -> readData loads word at read pointer on that same edge, read pointer +1 mod DEPTH, count -1.
REQ-015 Read latency SHALL be one cycle: data valid on readData immediately after the edge that sampled readEn.
REQ-016 readData SHALL hold its last value when no read is accepted.
REQ-017 Write while full SHALL be ignored (no storage, pointer or count change), even if a read is accepted in the same cycle.
REQ-018 Read while empty SHALL be ignored, even if a write is accepted in the same cycle; readData unchanged.
REQ-019 Simultaneous accepted read and write (0 < count < DEPTH) SHALL leave count unchanged and advance both pointers.
REQ-020 full and empty SHALL be registered/derived from count: full = (count == DEPTH), empty = (count == 0); both visible the cycle after the causing edge.
REQ-021 Data SHALL be returned strictly in write order across pointer wrap-around.
REQ-022 A word written at edge N SHALL be readable by a read sampled at edge N+1.

Reset
REQ-023 rst_n=0 at a rising edge SHALL clear pointers and count, set empty=1, full=0, readData=0.
REQ-024 Reset SHALL take priority over simultaneous writeEn/readEn; requests in that cycle are discarded.
REQ-025 Storage array contents SHALL NOT be reset; content is unreachable until rewritten.
REQ-026 Reset asserted mid-operation SHALL discard all stored words.
REQ-027 Before the first reset, output values are undefined.

Configuration
REQ-028 Macro FIFO_STATUS_EN defined: outputs overflow and underflow exist; overflow sets on a write ignored per REQ-017, underflow sets on a read ignored per REQ-018; both remain set until reset, which clears them to 0.
REQ-029 FIFO_STATUS_EN undefined: ports overflow and underflow and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset, write 0x01, read next cycle -> readData=0x01 one cycle later, empty=1 afterwards.
REQ-031 Write 0x01..0x08 on 8 consecutive cycles -> full=1, empty=0; 9th write 0x09 ignored.
REQ-032 Then 8 consecutive reads -> readData 0x01..0x08 in order, one per cycle; empty=1, full=0 after last.
REQ-033 Read while empty -> readData holds previous value, count stays 0; with FIFO_STATUS_EN underflow=1.
REQ-034 Fill to 4 then issue 12 cycles of simultaneous read+write of incrementing data -> count stays 4, order preserved across wrap.
REQ-035 Assert rst_n=0 with 5 words stored and writeEn=1 -> empty=1, full=0, readData=0, overflow/underflow=0.
